fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding and
// the width helpers used to size pointers and beat counters.
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF     = 4;
    localparam int MAXBEATS_DEF = 16;
    localparam int PTR_W_DEF    = $clog2(NREQ_DEF);
    localparam int CNT_W_DEF    = $clog2(MAXBEATS_DEF + 1);

    // Round-robin pointer width; at least one bit even for tiny configs.
    function automatic int ptr_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Beat counter must be able to hold the value MAXBEATS itself.
    function automatic int cnt_w(input int maxbeats);
        return $clog2(maxbeats + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping NREQ-1 -> 0, returned one-hot (all zero when nothing requests).
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(ptr) + k >= NREQ) begin
                idx = PTR_W'(int'(ptr) + k - NREQ);
            end else begin
                idx = PTR_W'(int'(ptr) + k);
            end
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level arbiter in front of an async FIFO write port: one requester
// owns the write port per packet, selected round-robin between packets.
//
// Handshake: a beat moves when the owner's req_valid and req_ready are both
// high on a wclk edge; req_ready = ~wfull for the owner and 0 otherwise, and
// winc pulses on exactly those edges with wdata = the owner's beat.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBEATS = 16
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    input  logic                  awfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ovf_err,
    output arb_state_t            state_dbg
);

    localparam int PTR_W = ptr_w(NREQ);
    localparam int CNT_W = cnt_w(MAXBEATS);

    arb_state_t       state, state_n;
    logic [NREQ-1:0]  grant_n, ovf_n, pick;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_n, owner_idx;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
    logic             xfer, owner_valid, owner_last, accept, at_max;

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .win (pick)
    );

    assign xfer        = (state == XFER);
    assign owner_valid = |(req_valid & grant);
    assign owner_last  = |(req_last & grant);
    assign accept      = xfer & owner_valid & ~wfull;
    assign at_max      = (beat_cnt == CNT_W'(MAXBEATS - 1));
    assign winc        = accept;
    assign req_ready   = xfer ? (grant & {NREQ{~wfull}}) : '0;
    assign state_dbg   = state;

    always_comb begin
        owner_idx = '0;
        wdata     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                owner_idx = PTR_W'(i);
                if (xfer) begin
                    wdata = req_data[i*DSIZE +: DSIZE];
                end
            end
        end
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        ovf_n      = ovf_err;
        case (state)
            IDLE: begin
                // Never open a packet into an almost-full FIFO.
                if ((|req_valid) && !awfull) begin
                    state_n    = XFER;
                    grant_n    = pick;
                    beat_cnt_n = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    beat_cnt_n = beat_cnt + 1'b1;
                    if (owner_last || at_max) begin
                        state_n  = IDLE;
                        grant_n  = '0;
                        rr_ptr_n = (owner_idx == PTR_W'(NREQ - 1)) ? '0 : owner_idx + 1'b1;
                        if (!owner_last) begin
                            ovf_n = ovf_err | grant;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            ovf_err  <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
            ovf_err  <= ovf_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: packet sources, a packet-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int MAXB  = 16;

    logic                  wclk = 1'b0;
    logic                  wrst_n = 1'b0;
    logic [NREQ-1:0]       req_valid, req_last, req_ready, grant, ovf_err;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  wfull, awfull, winc;
    logic [DSIZE-1:0]      wdata;
    arb_state_t            state_dbg;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    int left[NREQ];
    int pkts[NREQ];
    int plen[NREQ];
    bit nolast[NREQ];

    int gnt_q[$];
    int gnt_cyc_q[$];
    int wr_cnt[NREQ];
    int winc_total;
    logic [NREQ-1:0] last_grant;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBEATS(MAXB)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .awfull    (awfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .ovf_err   (ovf_err),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (left[i] > 0);
            req_last[i]  = (left[i] == 1) && !nolast[i];
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0; pkts[i] = 0; plen[i] = 0; nolast[i] = 1'b0;
        end
        drive_inputs();
    endtask

    // One clock: note accepted beats, then advance sources just after the edge.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        @(negedge wclk);
        acc = req_valid & req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                left[i]--;
                if (left[i] == 0 && pkts[i] > 0) begin
                    pkts[i]--;
                    left[i] = plen[i];
                end
            end
        end
        drive_inputs();
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] exp, input int budget, input string name);
        int n = 0;
        while (grant !== exp && n < budget) begin cycle(); n++; end
        if (grant !== exp) timeout_fail(name);
    endtask

    task automatic wait_any_grant(input int budget, input string name);
        int n = 0;
        while (grant === '0 && n < budget) begin cycle(); n++; end
        if (grant === '0) timeout_fail(name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        bit busy = 1'b1;
        while (busy && n < budget) begin
            busy = (grant !== '0);
            for (int i = 0; i < NREQ; i++) if (left[i] != 0 || pkts[i] != 0) busy = 1'b1;
            if (busy) begin cycle(); n++; end
        end
        if (busy) timeout_fail(name);
    endtask

    // Reference model: owner (-1 when nobody holds the port), next search
    // start, beats in the current packet and the sticky overflow flags.
    initial begin : model
        int own, ptr, beats, n_own, n_ptr, n_beats, c;
        logic [NREQ-1:0] ovf, n_ovf, e_grant, e_ready;
        logic e_winc;
        logic [DSIZE-1:0] e_wdata;
        own = -1; ptr = 0; beats = 0; ovf = '0; last_grant = '0;
        forever begin
            @(negedge wclk);
            if (!wrst_n) begin own = -1; ptr = 0; beats = 0; ovf = '0; end
            e_grant = '0; e_ready = '0; e_winc = 1'b0; e_wdata = '0;
            if (own >= 0) begin
                e_grant[own] = 1'b1;
                if (!wfull) e_ready[own] = 1'b1;
                e_winc  = req_valid[own] && !wfull;
                e_wdata = req_data[own*DSIZE +: DSIZE];
            end
            check("grant", 32'(grant), 32'(e_grant));
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("winc", 32'(winc), 32'(e_winc));
            check("wdata", 32'(wdata), 32'(e_wdata));
            check("ovf_err", 32'(ovf_err), 32'(ovf));
            check("state", 32'(state_dbg), (own >= 0) ? 32'd1 : 32'd0);

            if (grant !== '0 && grant !== last_grant) begin
                for (int i = 0; i < NREQ; i++) if (grant[i]) gnt_q.push_back(i);
                gnt_cyc_q.push_back(cyc);
            end
            last_grant = grant;
            if (winc === 1'b1) begin
                winc_total++;
                for (int i = 0; i < NREQ; i++) if (grant[i]) wr_cnt[i]++;
            end

            n_own = own; n_ptr = ptr; n_beats = beats; n_ovf = ovf;
            if (own < 0) begin
                if (req_valid != '0 && !awfull) begin
                    for (int k = NREQ - 1; k >= 0; k--) begin
                        c = (ptr + k) % NREQ;
                        if (req_valid[c]) n_own = c;
                    end
                    n_beats = 0;
                end
            end else if (e_winc) begin
                n_beats = beats + 1;
                if (req_last[own] || n_beats == MAXB) begin
                    n_own = -1;
                    n_ptr = (own + 1) % NREQ;
                    if (!req_last[own]) n_ovf[own] = 1'b1;
                end
            end
            @(posedge wclk);
            cyc++;
            if (wrst_n) begin own = n_own; ptr = n_ptr; beats = n_beats; ovf = n_ovf; end
        end
    end

    initial begin : watchdog
        #200000;
        timeout_fail("global_watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        wfull = 1'b0; awfull = 1'b0;
        req_valid = '0; req_last = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = 8'hA0 + 8'(i);
        for (int i = 0; i < NREQ; i++) wr_cnt[i] = 0;
        winc_total = 0;
        clear_sources();

        // Reset state
        repeat (3) cycle();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_winc", 32'(winc), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_wdata", 32'(wdata), 32'h0);
        check("rst_ovf", 32'(ovf_err), 32'h0);
        wrst_n = 1'b1;
        cycle();

        // All four requesting 2-beat packets; requester 0 has a second packet.
        gnt_q.delete(); gnt_cyc_q.delete(); winc_total = 0;
        for (int i = 0; i < NREQ; i++) begin plen[i] = 2; left[i] = 2; end
        pkts[0] = 1;
        drive_inputs();
        wait_idle(40, "rr_idle");
        check("rr_n_grants", 32'(gnt_q.size()), 32'd5);
        if (gnt_q.size() == 5) begin
            check("rr_g0", 32'(gnt_q[0]), 32'd0);
            check("rr_g1", 32'(gnt_q[1]), 32'd1);
            check("rr_g2", 32'(gnt_q[2]), 32'd2);
            check("rr_g3", 32'(gnt_q[3]), 32'd3);
            check("rr_g4", 32'(gnt_q[4]), 32'd0);
            for (int k = 1; k < 5; k++) check("rr_gap", 32'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 32'd3);
        end
        check("rr_winc_total", 32'(winc_total), 32'd10);

        // wfull stalls requester 2 mid-packet.
        for (int i = 0; i < NREQ; i++) wr_cnt[i] = 0;
        left[2] = 4; drive_inputs();
        wait_grant(4'b0100, 5, "full_grant");
        cycle();
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("full_winc", 32'(winc), 32'h0);
            check("full_ready", 32'(req_ready), 32'h0);
            cycle();
        end
        wfull = 1'b0;
        wait_idle(10, "full_idle");
        check("full_beats_req2", 32'(wr_cnt[2]), 32'd4);

        // awfull blocks a new grant; requester 1 granted on the edge after it clears.
        awfull = 1'b1;
        left[1] = 2; drive_inputs();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("awfull_no_grant", 32'(grant), 32'h0);
        end
        awfull = 1'b0;
        cycle();
        check("awfull_grant", 32'(grant), 32'b0010);
        wait_idle(10, "awfull_idle");

        // Requester 3: 20 beats, no last -> truncated at 16.
        for (int i = 0; i < NREQ; i++) wr_cnt[i] = 0;
        nolast[3] = 1'b1; left[3] = 20; left[1] = 2; drive_inputs();
        wait_grant(4'b1000, 5, "ovf_grant");
        begin
            int n = 0;
            while (grant === 4'b1000 && n < 30) begin cycle(); n++; end
            if (grant === 4'b1000) timeout_fail("ovf_release");
        end
        check("ovf_beats", 32'(wr_cnt[3]), 32'd16);
        check("ovf_left", 32'(left[3]), 32'd4);
        check("ovf_flag", 32'(ovf_err), 32'b1000);
        wait_any_grant(5, "ovf_next");
        check("ovf_next_grant", 32'(grant), 32'b0010);
        wait_grant(4'b1000, 10, "ovf_regrant");
        begin
            int n = 0;
            while (left[3] != 0 && n < 10) begin cycle(); n++; end
            if (left[3] != 0) timeout_fail("ovf_drain");
        end
        repeat (3) cycle();
        check("hold_grant", 32'(grant), 32'b1000);
        check("hold_winc", 32'(winc), 32'h0);
        check("hold_ovf", 32'(ovf_err), 32'b1000);

        // Reset clears the stuck owner and flags.
        wrst_n = 1'b0;
        clear_sources();
        cycle();
        check("rst2_grant", 32'(grant), 32'h0);
        check("rst2_ovf", 32'(ovf_err), 32'h0);
        wrst_n = 1'b1;

        // Reset during beat 3 of requester 1, then all request.
        left[1] = 6; drive_inputs();
        wait_grant(4'b0010, 5, "rst_mid_grant");
        cycle(); cycle();
        check("rst_mid_beat3_winc", 32'(winc), 32'h1);
        #2;
        wrst_n = 1'b0;
        #1;
        check("rst_mid_grant0", 32'(grant), 32'h0);
        check("rst_mid_winc0", 32'(winc), 32'h0);
        check("rst_mid_ready0", 32'(req_ready), 32'h0);
        cycle();
        clear_sources();
        for (int i = 0; i < NREQ; i++) left[i] = 2;
        drive_inputs();
        cycle();
        wrst_n = 1'b1;
        wait_any_grant(5, "post_rst_grant");
        check("post_rst_first", 32'(grant), 32'b0001);
        check("post_rst_winc", 32'(winc), 32'h1);
        check("post_rst_wdata", 32'(wdata), 32'hA0);
        wait_idle(40, "post_rst_idle");
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
